// File: rtl/wb_bus_arbiter.sv
// rtl/wb_bus_arbiter.sv - round-robin arbiter and burst sequencer for the 4-input write-back bus
// Grants one requester at a time, drives the bus select and releases on last, burst limit or abandon.
module wb_bus_arbiter #(
    parameter int DATA_WIDTH = 16,
    parameter int MAX_BEATS  = 8,
    parameter int CNT_W      = 3
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [3:0]            req,
    input  logic [3:0]            last,
    input  logic [DATA_WIDTH-1:0] data0,
    input  logic [DATA_WIDTH-1:0] data1,
    input  logic [DATA_WIDTH-1:0] data2,
    input  logic [DATA_WIDTH-1:0] data3,
    input  logic                  out_ready,
    output logic [3:0]            gnt,
    output logic [1:0]            sel,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    output logic                  busy
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BEATS - 1);

    logic [0:0]       r_state;
    logic [3:0]       r_gnt;
    logic [1:0]       r_sel;
    logic [1:0]       r_ptr;
    logic [CNT_W-1:0] r_beat_cnt;

    logic [1:0]       w_winner;
    logic [1:0]       w_scan_idx;
    logic             w_found;
    logic             w_valid;
    logic             w_beat;
    logic             w_release;

    // Scan from the highest offset down so the offset nearest ptr wins.
    always_comb begin
        w_found    = 1'b0;
        w_winner   = r_ptr;
        w_scan_idx = r_ptr;
        for (int k = 3; k >= 0; k--) begin
            w_scan_idx = r_ptr + 2'(k);
            if (req[w_scan_idx]) begin
                w_winner = w_scan_idx;
                w_found  = 1'b1;
            end
        end
    end

    assign w_valid   = (|r_gnt) & req[r_sel];
    assign w_beat    = w_valid & out_ready;
    assign w_release = ~req[r_sel] | (w_beat & (last[r_sel] | (r_beat_cnt == CNT_LAST)));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_gnt      <= 4'b0000;
            r_sel      <= 2'd0;
            r_ptr      <= 2'd0;
            r_beat_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_gnt      <= 4'b0001 << w_winner;
                        r_sel      <= w_winner;
                        r_beat_cnt <= '0;
                        r_state    <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (w_release) begin
                        r_gnt      <= 4'b0000;
                        r_state    <= ST_IDLE;
                        r_ptr      <= r_sel + 2'd1;
                        r_beat_cnt <= '0;
                    end else if (w_beat) begin
                        r_beat_cnt <= r_beat_cnt + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        out_data = data0;
        case (r_sel)
            2'd0: out_data = data0;
            2'd1: out_data = data1;
            2'd2: out_data = data2;
            2'd3: out_data = data3;
            default: out_data = data0;
        endcase
    end

    assign gnt       = r_gnt;
    assign sel       = r_sel;
    assign out_valid = w_valid;
    assign busy      = (r_state == ST_BUSY);

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// tb/tb_wb_bus_arbiter.sv - randomized bench for wb_bus_arbiter against an owner/pointer reference model
module tb_wb_bus_arbiter;

    localparam int DW   = 16;
    localparam int MAXB = 8;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [3:0]    req, last;
    logic [DW-1:0] data0, data1, data2, data3;
    logic          out_ready;
    logic [3:0]    gnt;
    logic [1:0]    sel;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          busy;

    int n_cmp = 0;
    int n_err = 0;

    int m_owner = -1;
    int m_sel   = 0;
    int m_ptr   = 0;
    int m_beats = 0;

    always #5 clk = ~clk;

    wb_bus_arbiter #(.DATA_WIDTH(DW), .MAX_BEATS(MAXB), .CNT_W(3)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .last(last),
        .data0(data0), .data1(data1), .data2(data2), .data3(data3),
        .out_ready(out_ready), .gnt(gnt), .sel(sel), .out_data(out_data),
        .out_valid(out_valid), .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] pick_data(input int s);
        case (s)
            0: return data0;
            1: return data1;
            2: return data2;
            default: return data3;
        endcase
    endfunction

    task automatic model_release();
        m_ptr   = (m_owner + 1) % 4;
        m_owner = -1;
        m_beats = 0;
    endtask

    task automatic model_edge();
        if (!reset_n) begin
            m_owner = -1; m_sel = 0; m_ptr = 0; m_beats = 0;
        end else if (m_owner < 0) begin
            for (int k = 0; k < 4; k++) begin
                if (m_owner < 0 && req[(m_ptr + k) % 4]) begin
                    m_owner = (m_ptr + k) % 4;
                    m_sel   = m_owner;
                    m_beats = 0;
                end
            end
        end else if (!req[m_owner]) begin
            model_release();
        end else if (out_ready) begin
            if (last[m_owner] || m_beats + 1 == MAXB) model_release();
            else m_beats++;
        end
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic step(input logic rn, input logic [3:0] rq, input logic [3:0] lt, input logic rdy);
        reset_n = rn; req = rq; last = lt; out_ready = rdy;
        data0 = DW'($urandom); data1 = DW'($urandom);
        data2 = DW'($urandom); data3 = DW'($urandom);
        #1;
        chk("gnt",       32'(gnt),       (m_owner < 0) ? 32'd0 : 32'(1 << m_owner));
        chk("sel",       32'(sel),       32'(m_sel));
        chk("busy",      32'(busy),      32'(m_owner >= 0));
        chk("out_valid", 32'(out_valid), 32'(m_owner >= 0 && req[m_owner]));
        chk("out_data",  32'(out_data),  32'(pick_data(m_sel)));
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    logic [3:0] rr_exp [9]  = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
                                4'b0000, 4'b1000, 4'b0000, 4'b0001};
    logic [3:0] frc_exp [10] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001,
                                 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b1000};

    initial begin
        logic [3:0] r_req;
        reset_n = 1'b0; req = '0; last = '0; out_ready = 1'b0;
        data0 = '0; data1 = '0; data2 = '0; data3 = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_gnt",   32'(gnt),       32'd0);
        chk("rst_sel",   32'(sel),       32'd0);
        chk("rst_busy",  32'(busy),      32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);

        // Round robin with every requester asking and finishing in one beat
        for (int i = 0; i < 9; i++) begin
            step(1'b1, 4'b1111, 4'b1111, 1'b1);
            chk("rr_gnt", 32'(gnt), 32'(rr_exp[i]));
        end

        // Burst limit forces release after MAX_BEATS beats
        step(1'b0, 4'b0000, 4'b0000, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 4'b1001, 4'b0000, 1'b1);
            chk("force_gnt", 32'(gnt), 32'(frc_exp[i]));
        end

        // Reset mid-burst, then requester 0 wins first
        step(1'b0, 4'b1111, 4'b0000, 1'b1);
        chk("midrst_gnt", 32'(gnt), 32'd0);
        step(1'b1, 4'b1111, 4'b0000, 1'b1);
        chk("post_rst_gnt", 32'(gnt), 32'b0001);

        r_req = 4'b0000;
        for (int i = 0; i < 3000; i++) begin
            for (int b = 0; b < 4; b++)
                if ($urandom_range(0, 9) == 0) r_req[b] = ~r_req[b];
            step(($urandom_range(0, 99) != 0),
                 r_req,
                 {($urandom_range(0, 6) == 0), ($urandom_range(0, 6) == 0),
                  ($urandom_range(0, 6) == 0), ($urandom_range(0, 6) == 0)},
                 ($urandom_range(0, 9) < 7));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
